// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state type, sizes and helpers for the 4:1 mux arbiter
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_4to1_arbiter_rr_pick.sv
// rtl/mux_4to1_arbiter_rr_pick.sv - rotating first-set-bit search over masked requests
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_start,
    input  logic [NUM_REQ-1:0] i_excl,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_found
);

    logic [NUM_REQ-1:0] w_cand_mask;
    logic [SEL_W-1:0]   w_cand;

    assign w_cand_mask = i_req & ~i_excl;

    // The index wraps naturally in SEL_W bits, so the slot before i_start is scanned last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = i_start + SEL_W'(i);
            if (!o_found && w_cand_mask[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_4to1_arbiter.sv
// rtl/mux_4to1_arbiter.sv - round-robin owner of a 4:1 mux select with one-hot grant
// Optional hold limit enabled by defining MUX_ARB_HOLD_LIMIT_EN.
module mux_4to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [SEL_W-1:0]   last
);

    arb_state_e         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic               r_busy, w_busy_nxt;
    logic [SEL_W-1:0]   r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_excl;
    logic [SEL_W-1:0]   w_start;
    logic [SEL_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic               w_hold;
    logic               w_others;
    logic               w_limit_hit;
    logic               w_force;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_owner_oh  = idx_to_onehot(r_sel);
    assign w_hold      = (r_state == OWN) && req[r_sel];
    assign w_others    = |(req & ~w_owner_oh);
    assign w_limit_hit = (r_cnt >= CNT_W'(HOLD_MAX - 1));
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_start     = r_last + SEL_W'(1);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    assign w_force = w_hold && w_limit_hit && w_others;
`else
    logic w_unused_limit;
    assign w_force        = 1'b0;
    assign w_unused_limit = w_limit_hit ^ w_others;
`endif

    // A forced hand-over masks the owner so it cannot win its own re-arbitration.
    assign w_excl = w_force ? w_owner_oh : '0;

    rr_pick u_rr_pick (
        .i_req   (req),
        .i_start (w_start),
        .i_excl  (w_excl),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_last  <= '1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick_found) begin
                    w_state_nxt = OWN;
                    w_gnt_nxt   = idx_to_onehot(w_pick_idx);
                    w_sel_nxt   = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = w_pick_idx;
                end
            end
            OWN: begin
                if (w_hold && !w_force) begin
                    w_cnt_nxt = w_cnt_inc;
                end else if (w_pick_found) begin
                    w_gnt_nxt  = idx_to_onehot(w_pick_idx);
                    w_sel_nxt  = w_pick_idx;
                    w_last_nxt = w_pick_idx;
                    w_cnt_nxt  = '0;
                end else begin
                    // sel is left alone so the mux input does not glitch on release.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign last = r_last;

endmodule
